// File: rtl/kw_arb_wrr_if.sv
// kw_arb_wrr_if: request/grant bundle for the weighted round-robin arbiter.
//   request     : per-requester request               (master -> slave)
//   mask        : per-requester ineligible flag       (master -> slave)
//   lock        : holder keeps grant, tenure frozen   (master -> slave)
//   weight      : N packed WW-bit tenure fields       (master -> slave)
//   grant       : one-hot grant                       (slave -> master)
//   grant_index : binary index of grant               (slave -> master)
//   granted     : grant belongs to an eligible holder (slave -> master)
//   locked      : current grant held by lock          (slave -> master)
//   parked      : no eligible requester               (slave -> master)
interface kw_arb_wrr_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned WW = 4
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    request;
  logic [N-1:0]    mask;
  logic [N-1:0]    lock;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_index;
  logic            granted;
  logic            locked;
  logic            parked;

  modport master (
    output request, mask, lock, weight,
    input  grant, grant_index, granted, locked, parked
  );

  modport slave (
    input  request, mask, lock, weight,
    output grant, grant_index, granted, locked, parked
  );
endinterface

// File: rtl/kw_arb_wrr.sv
// kw_arb_wrr: weighted round-robin arbiter with lock and park.
// Each winner holds the grant for max(weight,1) cycles, or indefinitely while
// it asserts lock; the rotating pointer then moves past the holder.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   io_arb : kw_arb_wrr_if.slave (request/mask/lock/weight in; grant,
//            grant_index, granted, locked, parked out, all registered)
// Build option: KW_ARB_WRR_PARK_EN defined -> idle grant parks on PARK_IDX;
// undefined -> idle grant is all-zero and parked stays 0.
module kw_arb_wrr #(
  parameter int unsigned N        = 16,
  parameter int unsigned WW       = 4,
  parameter int unsigned PARK_IDX = 0
) (
  input logic          i_clk,
  input logic          i_rst,
  kw_arb_wrr_if.slave  io_arb
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || PARK_IDX >= N) begin : g_bad_cfg
    $error("kw_arb_wrr: requires N >= 2 and PARK_IDX < N");
  end

`ifdef KW_ARB_WRR_PARK_EN
  localparam logic [N-1:0]  PARK_GRANT = N'(1) << PARK_IDX;
  localparam logic [IW-1:0] PARK_INDEX = IW'(PARK_IDX);
  localparam logic          PARK_FLAG  = 1'b1;
`else
  localparam logic [N-1:0]  PARK_GRANT = '0;
  localparam logic [IW-1:0] PARK_INDEX = '0;
  localparam logic          PARK_FLAG  = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_hold, w_hold_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [WW-1:0] r_cnt, w_cnt_nxt;

  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [IW-1:0] r_grant_index, w_grant_index_nxt;
  logic          r_granted, w_granted_nxt;
  logic          r_locked, w_locked_nxt;
  logic          r_parked, w_parked_nxt;

  logic [N-1:0]  w_elig;
  logic [WW-1:0] w_weight;
  logic [WW-1:0] w_lim;
  logic [IW-1:0] w_ptr_inc;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_win;
  logic          w_any;
  logic          w_hold_lock;
  logic          w_stay;

  assign w_elig      = io_arb.request & ~io_arb.mask;
  assign w_hold_lock = io_arb.lock[r_hold];

  // Live weight of the current holder
  always_comb begin : weight_sel
    w_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (r_hold == IW'(i)) w_weight = io_arb.weight[i*WW +: WW];
    end
  end

  // Last tenure count value that still keeps the grant (weight 0 acts as 1)
  assign w_lim     = (w_weight == '0) ? '0 : w_weight - WW'(1);
  assign w_ptr_inc = (r_hold == IW'(N - 1)) ? '0 : r_hold + IW'(1);
  // Leaving HOLD scans from the already-advanced pointer so h loses priority
  assign w_base    = (r_state == ST_HOLD) ? w_ptr_inc : r_ptr;

  // Rotating first-eligible search starting at w_base
  always_comb begin : rr_scan
    int unsigned idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(w_base) + k;
      if (idx >= N) idx = idx - N;
      if (!w_any && w_elig[IW'(idx)]) begin
        w_any = 1'b1;
        w_win = IW'(idx);
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin : fsm_next
    w_state_nxt       = r_state;
    w_hold_nxt        = r_hold;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_locked_nxt      = 1'b0;
    w_grant_nxt       = PARK_GRANT;
    w_grant_index_nxt = PARK_INDEX;
    w_granted_nxt     = 1'b0;
    w_parked_nxt      = PARK_FLAG;
    w_stay            = w_elig[r_hold] & (w_hold_lock | (r_cnt < w_lim));

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = w_win;
          w_cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (w_stay) begin
          if (!w_hold_lock) w_cnt_nxt = r_cnt + WW'(1);
          w_locked_nxt = w_hold_lock;
        end else begin
          w_ptr_nxt = w_ptr_inc;
          w_cnt_nxt = '0;
          if (w_any) w_hold_nxt  = w_win;
          else       w_state_nxt = ST_IDLE;
        end
      end
    endcase

    if (w_state_nxt == ST_HOLD) begin
      w_grant_nxt       = N'(1) << w_hold_nxt;
      w_grant_index_nxt = w_hold_nxt;
      w_granted_nxt     = 1'b1;
      w_parked_nxt      = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin : state_reg
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_grant       <= PARK_GRANT;
      r_grant_index <= PARK_INDEX;
      r_granted     <= 1'b0;
      r_locked      <= 1'b0;
      r_parked      <= PARK_FLAG;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_index <= w_grant_index_nxt;
      r_granted     <= w_granted_nxt;
      r_locked      <= w_locked_nxt;
      r_parked      <= w_parked_nxt;
    end
  end

  assign io_arb.grant       = r_grant;
  assign io_arb.grant_index = r_grant_index;
  assign io_arb.granted     = r_granted;
  assign io_arb.locked      = r_locked;
  assign io_arb.parked      = r_parked;

endmodule

// File: tb/tb_kw_arb_wrr.sv
// tb_kw_arb_wrr: directed vector table, hand sequences for multi-cycle
// corners, then randomized traffic against a behavioural model.
module tb_kw_arb_wrr;
  localparam int unsigned N        = 16;
  localparam int unsigned WW       = 4;
  localparam int unsigned PARK_IDX = 0;

  localparam logic [63:0] W1  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W3  = 64'h1111_1111_1111_1013;
  localparam logic [63:0] W8  = 64'h1111_1111_1111_1181;
  localparam logic [63:0] W2  = 64'h1111_1111_1111_1121;
  localparam logic [63:0] W38 = 64'h1111_1111_1111_8111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kw_arb_wrr_if #(.N(N), .WW(WW)) bus ();

  kw_arb_wrr #(.N(N), .WW(WW), .PARK_IDX(PARK_IDX)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_arb(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] msk;
    logic [15:0] lk;
    logic [63:0] wgt;
    logic [15:0] grant;
    logic        granted;
    logic        parked;
    logic        locked;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [15:0] req, input logic [15:0] msk,
                              input logic [15:0] lk, input logic [63:0] wgt,
                              input logic [15:0] g, input logic gd, input logic pk,
                              input logic lo);
    vec_t v;
    v.rst = r; v.req = req; v.msk = msk; v.lk = lk; v.wgt = wgt;
    v.grant = g; v.granted = gd; v.parked = pk; v.locked = lo;
    return v;
  endfunction

  function automatic logic [3:0] oh_idx(input logic [15:0] g);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (g[i]) r = 4'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] eg, input logic [3:0] ei,
                            input logic egd, input logic epk, input logic elo);
    chk({tag, " grant"},       32'(bus.grant),       32'(eg));
    chk({tag, " grant_index"}, 32'(bus.grant_index), 32'(ei));
    chk({tag, " granted"},     32'(bus.granted),     32'(egd));
    chk({tag, " parked"},      32'(bus.parked),      32'(epk));
    chk({tag, " locked"},      32'(bus.locked),      32'(elo));
  endtask

  // Apply one vector for one clock and compare the registered outputs
  task automatic apply_vec(input string tag, input vec_t v);
    logic [15:0] eg;
    logic        ep;
    rst = v.rst; bus.request = v.req; bus.mask = v.msk; bus.lock = v.lk; bus.weight = v.wgt;
    eg = v.grant;
    ep = v.parked;
`ifndef KW_ARB_WRR_PARK_EN
    if (v.parked) begin
      eg = '0;
      ep = 1'b0;
    end
`endif
    @(posedge clk);
    #1;
    check_outs(tag, eg, oh_idx(eg), v.granted, ep, v.locked);
  endtask

  // Behavioural reference: holder, tenure count and rotating start position
  bit          m_busy;
  int          m_h, m_cnt, m_ptr;
  logic [15:0] e_grant;
  logic [3:0]  e_idx;
  logic        e_granted, e_parked, e_locked;

  task automatic model_step(input logic r, input logic [15:0] req, input logic [15:0] msk,
                            input logic [15:0] lk, input logic [63:0] wgt);
    logic [15:0] elig;
    int          pick;
    int          weff;
    elig     = req & ~msk;
    pick     = -1;
    e_locked = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_h = 0;
    end else begin
      weff = 1;
      if (m_busy) begin
        weff = int'(wgt[m_h*4 +: 4]);
        if (weff == 0) weff = 1;
      end
      if (m_busy && elig[m_h] && (lk[m_h] || (m_cnt + 1 < weff))) begin
        if (!lk[m_h]) m_cnt = m_cnt + 1;
        e_locked = lk[m_h];
      end else begin
        if (m_busy) m_ptr = (m_h + 1) % N;
        for (int k = 0; k < N; k++) begin
          if (pick < 0 && elig[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        end
        if (pick >= 0) begin
          m_busy = 1'b1; m_h = pick; m_cnt = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
    if (m_busy) begin
      e_grant = 16'(1) << m_h; e_idx = 4'(m_h); e_granted = 1'b1; e_parked = 1'b0;
    end else begin
`ifdef KW_ARB_WRR_PARK_EN
      e_grant = 16'(1) << PARK_IDX; e_idx = 4'(PARK_IDX); e_parked = 1'b1;
`else
      e_grant = '0; e_idx = '0; e_parked = 1'b0;
`endif
      e_granted = 1'b0;
    end
  endtask

  initial begin
    logic        r;
    logic [15:0] req, msk, lk;
    logic [63:0] wgt;

    rst = 1'b1; bus.request = '0; bus.mask = '0; bus.lock = '0; bus.weight = W1;

    // Reset, round robin, weights, idle pointer retention, lock, mask
    vecs.push_back(mk(1, 16'h0000, 16'h0, 16'h0, W1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0000, 16'h0, 16'h0, W1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 16'h0, W1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 16'h0, W1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W1, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W1, 16'h0004, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W1, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W1, 16'h0004, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W3, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W3, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W3, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W3, 16'h0004, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W3, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 16'h0, W1, 16'h0001, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0005, 16'h0, 16'h0, W1, 16'h0004, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 16'h000F, 16'h0, 16'h0004, W1, 16'h0004, 1, 0, 1));
    vecs.push_back(mk(0, 16'h000F, 16'h0, 16'h0000, W1, 16'h0008, 1, 0, 0));
    vecs.push_back(mk(0, 16'h000F, 16'h0, 16'h0004, W1, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0003, 16'h1, 16'h0000, W8, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0003, 16'h1, 16'h0000, W8, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0003, 16'h1, 16'h0000, W8, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0003, 16'h2, 16'h0000, W8, 16'h0001, 1, 0, 0));

    foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Lowering the live weight below cnt+1 ends the tenure at the next edge
    for (int i = 0; i < 4; i++)
      apply_vec($sformatf("wlow%0d", i), mk(0, 16'h0003, 16'h0, 16'h0, W8, 16'h0002, 1, 0, 0));
    apply_vec("wlow_end", mk(0, 16'h0003, 16'h0, 16'h0, W2, 16'h0001, 1, 0, 0));

    // Reset mid-tenure restarts the pointer at 0
    for (int i = 0; i < 5; i++)
      apply_vec($sformatf("midrst%0d", i), mk(0, 16'h0008, 16'h0, 16'h0, W38, 16'h0008, 1, 0, 0));
    apply_vec("midrst_rst",  mk(1, 16'h000C, 16'h0, 16'h0, W38, 16'h0001, 0, 1, 0));
    apply_vec("midrst_arb",  mk(0, 16'h000C, 16'h0, 16'h0, W38, 16'h0004, 1, 0, 0));
    apply_vec("midrst_next", mk(0, 16'h000C, 16'h0, 16'h0, W38, 16'h0008, 1, 0, 0));
    // Lock from a holder that dropped its request is ignored
    apply_vec("lock_inelig", mk(0, 16'h0004, 16'h0, 16'h0008, W38, 16'h0004, 1, 0, 0));

    // Randomized traffic against the model
    req = '0; msk = '0; lk = '0; wgt = W1;
    for (int i = 0; i < 3000; i++) begin
      r = (i == 0) || ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) msk = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        lk = ($urandom_range(0, 5) == 0) ? 16'hFFFF : (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 15) == 0) wgt = {$urandom, $urandom};
      rst = r; bus.request = req; bus.mask = msk; bus.lock = lk; bus.weight = wgt;
      model_step(r, req, msk, lk, wgt);
      @(posedge clk);
      #1;
      check_outs($sformatf("rand%0d", i), e_grant, e_idx, e_granted, e_parked, e_locked);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
